// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the instruction issue controller.
//   WORD_W         instruction word width
//   OPC_HI/OPC_LO  opcode field bounds within an instruction word
//   NOP_WORD       bubble encoding (opcode 0, never raises a hazard)
//   pipe_word_t    instruction word type
//   NUM_STAGES     number of execution pipeline stages
package pipe_pkg;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned OPC_HI     = 15;
    localparam int unsigned OPC_LO     = 9;
    localparam int unsigned NUM_STAGES = 5;

    typedef logic [WORD_W-1:0] pipe_word_t;

    localparam pipe_word_t NOP_WORD = '0;

    function automatic logic [OPC_HI-OPC_LO:0] opcode_of(input pipe_word_t word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// issue_fifo: synchronous FIFO feeding stage 1 of the pipeline.
//   clk, rst_n  clock, asynchronous active-low reset
//   push, wdata write wdata at the tail (caller guarantees not full)
//   pop         advance the head (caller guarantees not empty)
//   clear       synchronous empty; overrides push and pop
//   rdata       current head word
//   count       number of stored words (0..DEPTH)
module issue_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointers are power-of-two wide so the increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; count gates every read that matters.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl: issue controller owning the five stage instruction registers.
// Each edge the stages shift dat1->dat5; stage 1 takes the fetch FIFO head unless
// a flush, a hazard (blocked) or an empty FIFO forces a NOP bubble.
//   clk, rst_n              clock, asynchronous active-low reset
//   fetch_data/valid/ready  fetch handshake into the FIFO
//   blocked                 hazard from the hazard unit (combinational on dat1..dat5)
//   flush                   branch redirect: empties FIFO, bubbles stage 1
//   dat1..dat5, stage_valid stage registers and their real-instruction flags
//   stall_clr, stall_count  hazard-bubble counter (PIPE_STALL_COUNTER_EN only)
// Build option: define PIPE_STALL_COUNTER_EN to build the saturating stall counter.
module pipe_issue_ctrl #(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] fetch_data,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic              blocked,
    input  logic              flush,
    output logic [WORD_W-1:0] dat1,
    output logic [WORD_W-1:0] dat2,
    output logic [WORD_W-1:0] dat3,
    output logic [WORD_W-1:0] dat4,
    output logic [WORD_W-1:0] dat5,
    output logic [4:0]        stage_valid,
    input  logic              stall_clr,
    output logic [15:0]       stall_count
);

    import pipe_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [WORD_W-1:0] NOP = WORD_W'(NOP_WORD);

    logic [CNT_W-1:0]  fifo_count;
    logic [WORD_W-1:0] fifo_head;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    logic [WORD_W-1:0] dat_q [NUM_STAGES];
    logic [NUM_STAGES-1:0] valid_q;
    logic [WORD_W-1:0] stage1_d;
    logic              stage1_valid_d;

    // No pass-through when full: readiness ignores a same-cycle pop.
    assign fetch_ready = !flush && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign push        = fetch_valid && fetch_ready;
    assign fifo_empty  = (fifo_count == '0);
    assign pop         = !flush && !blocked && !fifo_empty;

    issue_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .wdata (fetch_data),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    always_comb begin
        stage1_d       = NOP;
        stage1_valid_d = 1'b0;
        if (pop) begin
            stage1_d       = fifo_head;
            stage1_valid_d = 1'b1;
        end
    end

    // The pipeline never stalls; hazards are absorbed by bubbles at stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                dat_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int i = NUM_STAGES - 1; i > 0; i--) begin
                dat_q[i] <= dat_q[i-1];
            end
            dat_q[0] <= stage1_d;
            valid_q  <= {valid_q[NUM_STAGES-2:0], stage1_valid_d};
        end
    end

    assign dat1        = dat_q[0];
    assign dat2        = dat_q[1];
    assign dat3        = dat_q[2];
    assign dat4        = dat_q[3];
    assign dat5        = dat_q[4];
    assign stage_valid = valid_q;

`ifdef PIPE_STALL_COUNTER_EN
    logic [15:0] stall_q;

    // Only hazard bubbles count; starvation (empty FIFO) and flushes do not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (stall_clr) begin
            stall_q <= '0;
        end else if (blocked && !flush && !fifo_empty && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`else
    logic unused_stall_clr;
    assign unused_stall_clr = stall_clr;
    assign stall_count      = '0;
`endif

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
module tb_pipe_issue_ctrl;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] fetch_data = '0;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic        blocked = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] dat1, dat2, dat3, dat4, dat5;
    logic [4:0]  stage_valid;
    logic        stall_clr = 1'b0;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    pipe_issue_ctrl #(
        .WORD_W     (16),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .blocked     (blocked),
        .flush       (flush),
        .dat1        (dat1),
        .dat2        (dat2),
        .dat3        (dat3),
        .dat4        (dat4),
        .dat5        (dat5),
        .stage_valid (stage_valid),
        .stall_clr   (stall_clr),
        .stall_count (stall_count)
    );

    int chk = 0;
    int err = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the pipe is a queue of slots (front = stage 1), the FIFO a word queue.
    typedef struct packed {
        logic [15:0] w;
        logic        v;
    } slot_t;

    typedef struct packed {
        logic [79:0] dats;
        logic [4:0]  v;
        logic [15:0] sc;
    } exp_t;

    slot_t       m_pipe[$];
    logic [15:0] m_fifo[$];
    int unsigned m_stall;
    exp_t        exp_q[$];

    task automatic model_reset();
        m_pipe.delete();
        for (int i = 0; i < 5; i++) m_pipe.push_back('0);
        m_fifo.delete();
        m_stall = 0;
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e = '0;
        for (int i = 0; i < 5; i++) begin
            e.dats[i*16 +: 16] = m_pipe[i].w;
            e.v[i]             = m_pipe[i].v;
        end
        e.sc = 16'(m_stall);
        return e;
    endfunction

    // Drive one cycle of stimulus at the falling edge and record the expected result.
    task automatic step(input logic fv, input logic [15:0] fd, input logic blk,
                        input logic fl, input logic clr);
        logic  exp_ready;
        logic  had_work;
        slot_t nslot;
        @(negedge clk);
        fetch_valid = fv;
        fetch_data  = fd;
        blocked     = blk;
        flush       = fl;
        stall_clr   = clr;
        #1;
        exp_ready = !fl && (m_fifo.size() < DEPTH);
        check("fetch_ready", 80'(fetch_ready), 80'(exp_ready));
        had_work = (m_fifo.size() != 0);
`ifdef PIPE_STALL_COUNTER_EN
        if (clr) m_stall = 0;
        else if (blk && !fl && had_work && m_stall < 65535) m_stall++;
`endif
        nslot = '0;
        if (fl) begin
            m_fifo.delete();
        end else begin
            if (!blk && had_work) nslot = '{w: m_fifo.pop_front(), v: 1'b1};
            if (fv && exp_ready) m_fifo.push_back(fd);
        end
        m_pipe.push_front(nslot);
        void'(m_pipe.pop_back());
        exp_q.push_back(snapshot());
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
        end
    endtask

    // Monitor: after every rising edge compare the DUT against the oldest expectation.
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("stages", {dat5, dat4, dat3, dat2, dat1}, mon_e.dats);
            check("stage_valid", 80'(stage_valid), 80'(mon_e.v));
            check("stall_count", 80'(stall_count), 80'(mon_e.sc));
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_stages"}, {dat5, dat4, dat3, dat2, dat1}, 80'h0);
        check({tag, "_valid"}, 80'(stage_valid), 80'h0);
        check({tag, "_ready"}, 80'(fetch_ready), 80'h1);
        check({tag, "_stall"}, 80'(stall_count), 80'h0);
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #10;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Stream three words unblocked, then let them drain to stage 5.
        step(1'b1, 16'h0201, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0402, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0603, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Fill the FIFO while blocked, then hold blocked three more cycles.
        step(1'b1, 16'h0a11, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h0c22, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0e33, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Starvation with blocked low and high: bubbles, never counted.
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Full FIFO then flush with a word offered: word dropped, FIFO emptied.
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h2345, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h3456, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h4567, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        rand_steps(400);

        // Asynchronous reset in the middle of a stall with a full FIFO.
        step(1'b1, 16'h5a5a, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h6b6b, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h7c7c, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        stall_clr   = 1'b0;
        rst_n       = 1'b0;
        #1;
        check_reset_state("async_reset");
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        rand_steps(300);

`ifdef PIPE_STALL_COUNTER_EN
        // Saturate the counter with a held hazard, then clear it.
        step(1'b1, 16'h0801, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h0802, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
`endif

        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        check("scoreboard_drained", 80'(exp_q.size()), 80'h0);

        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
